// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480 timing and the genlock window test.
package vga_timing_pkg;

   typedef enum logic {StFree, StLocked} state_e;

   localparam int unsigned DefHActive = 640;
   localparam int unsigned DefHFp     = 16;
   localparam int unsigned DefHSync   = 96;
   localparam int unsigned DefHBp     = 48;
   localparam int unsigned DefVActive = 480;
   localparam int unsigned DefVFp     = 10;
   localparam int unsigned DefVSync   = 2;
   localparam int unsigned DefVBp     = 33;

   // True when v lies within +/-tol of lock_line on the circular 0..v_total-1 line space.
   function automatic logic in_window(input int unsigned v, input int unsigned lock_line,
                                      input int unsigned tol, input int unsigned v_total);
      int unsigned d;
      d = (v >= lock_line) ? (v - lock_line) : (v + v_total - lock_line);
      return (d <= tol) || (d + tol >= v_total);
   endfunction

endpackage

// File: rtl/sync_region.sv
// Active/sync region decode for one axis (horizontal or vertical) of the raster.
module sync_region #(
   parameter int unsigned ACTIVE   = 640,
   parameter int unsigned FRONT    = 16,
   parameter int unsigned SYNC_LEN = 96,
   parameter int unsigned W        = 10
) (
   input  logic [W-1:0] cnt_i,
   output logic         active_o,
   output logic         sync_o
);

   localparam logic [W-1:0] ActiveEnd = W'(ACTIVE);
   localparam logic [W-1:0] SyncFirst = W'(ACTIVE + FRONT);
   localparam logic [W-1:0] SyncLast  = W'(ACTIVE + FRONT + SYNC_LEN - 1);

   // Pure comparator; polarity is applied by the caller
   always_comb begin
      active_o = (cnt_i < ActiveEnd);
      sync_o   = (cnt_i >= SyncFirst) && (cnt_i <= SyncLast);
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing with genlock to an external frame sync and line-buffer read addressing.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = DefHActive,
   parameter int unsigned H_FP      = DefHFp,
   parameter int unsigned H_SYNC    = DefHSync,
   parameter int unsigned H_BP      = DefHBp,
   parameter int unsigned V_ACTIVE  = DefVActive,
   parameter int unsigned V_FP      = DefVFp,
   parameter int unsigned V_SYNC    = DefVSync,
   parameter int unsigned V_BP      = DefVBp,
   parameter bit          HS_POL    = 1'b0,
   parameter bit          VS_POL    = 1'b0,
   parameter int unsigned PIX_REP   = 1,
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned LOCK_LINE = 0,
   parameter int unsigned LOCK_TOL  = 2,
   parameter int unsigned MISS_MAX  = 3
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              SYNC,
   input  logic              SYNC_EN,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_VISIBLE,
   output logic [ADDR_W-1:0] BRAM_ADDR,
   output logic              LOCKED
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW       = $clog2(H_TOTAL);
   localparam int unsigned VW       = $clog2(V_TOTAL);
   localparam int unsigned MW       = $clog2(MISS_MAX + 1);
   localparam int unsigned RepShift = (PIX_REP == 2) ? 1 : 0;

   localparam logic [HW-1:0] HLast    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] VLast    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VLock    = VW'(LOCK_LINE);
   localparam logic [MW-1:0] MissLast = MW'(MISS_MAX - 1);

   state_e            state_q, state_d;
   logic [HW-1:0]     h_q, h_d;
   logic [VW-1:0]     v_q, v_d;
   logic [MW-1:0]     miss_q, miss_d;
   logic [1:0]        nosync_q, nosync_d;
   logic              seen_q, seen_d;
   logic              sync_q, sync_d;
   logic              hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
   logic              hs2_q, hs2_d, vs2_q, vs2_d, vis2_q, vis2_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic sync_edge, h_wrap, v_wrap, in_win, load;
   logic h_act, h_sync, v_act, v_sync;

   assign sync_edge = SYNC & ~sync_q;
   assign h_wrap    = (h_q == HLast);
   assign v_wrap    = h_wrap && (v_q == VLast);
   assign in_win    = in_window(32'(v_q), LOCK_LINE, LOCK_TOL, V_TOTAL);

   sync_region #(
      .ACTIVE  (H_ACTIVE),
      .FRONT   (H_FP),
      .SYNC_LEN(H_SYNC),
      .W       (HW)
   ) u_h_region (
      .cnt_i   (h_q),
      .active_o(h_act),
      .sync_o  (h_sync)
   );

   sync_region #(
      .ACTIVE  (V_ACTIVE),
      .FRONT   (V_FP),
      .SYNC_LEN(V_SYNC),
      .W       (VW)
   ) u_v_region (
      .cnt_i   (v_q),
      .active_o(v_act),
      .sync_o  (v_sync)
   );

   // Genlock state machine and raster counter next-state
   always_comb begin
      state_d  = state_q;
      miss_d   = miss_q;
      nosync_d = nosync_q;
      seen_d   = seen_q;
      load     = 1'b0;
      sync_d   = SYNC;
      unique case (state_q)
         StFree: begin
            if (sync_edge && SYNC_EN) begin
               load     = 1'b1;
               miss_d   = '0;
               nosync_d = '0;
               seen_d   = 1'b1;
               state_d  = StLocked;
            end
         end
         StLocked: begin
            if (!SYNC_EN) begin
               state_d = StFree;
            end else if (sync_edge) begin
               nosync_d = '0;
               if (in_win) begin
                  miss_d = '0;
               end else if (miss_q == MissLast) begin
                  load   = 1'b1;
                  miss_d = '0;
               end else begin
                  miss_d = miss_q + 1'b1;
               end
               // An edge on the wrap cycle itself is credited to the frame that just ended
               seen_d = !(v_wrap && !load);
            end else if (v_wrap) begin
               seen_d = 1'b0;
               if (!seen_q) begin
                  nosync_d = nosync_q + 2'd1;
                  if (nosync_q == 2'd1) state_d = StFree;
               end
            end
         end
      endcase

      if (load) begin
         h_d = '0;
         v_d = VLock;
      end else if (h_wrap) begin
         h_d = '0;
         v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end else begin
         h_d = h_q + 1'b1;
         v_d = v_q;
      end
   end

   // Output decode; sync/visible take a second stage so they line up with RAM read data
   always_comb begin
      vis1_d = h_act & v_act;
      hs1_d  = h_sync ? HS_POL : ~HS_POL;
      vs1_d  = v_sync ? VS_POL : ~VS_POL;
      addr_d = vis1_d ? {v_q[0], (ADDR_W-1)'(h_q >> RepShift)} : '0;
      hs2_d  = hs1_q;
      vs2_d  = vs1_q;
      vis2_d = vis1_q;
   end

   // State and pipeline registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= StFree;
         h_q      <= '0;
         v_q      <= '0;
         miss_q   <= '0;
         nosync_q <= '0;
         seen_q   <= 1'b0;
         sync_q   <= 1'b0;
         hs1_q    <= ~HS_POL;
         vs1_q    <= ~VS_POL;
         vis1_q   <= 1'b0;
         hs2_q    <= ~HS_POL;
         vs2_q    <= ~VS_POL;
         vis2_q   <= 1'b0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         v_q      <= v_d;
         miss_q   <= miss_d;
         nosync_q <= nosync_d;
         seen_q   <= seen_d;
         sync_q   <= sync_d;
         hs1_q    <= hs1_d;
         vs1_q    <= vs1_d;
         vis1_q   <= vis1_d;
         hs2_q    <= hs2_d;
         vs2_q    <= vs2_d;
         vis2_q   <= vis2_d;
         addr_q   <= addr_d;
      end
   end

   assign VGA_HS      = hs2_q;
   assign VGA_VS      = vs2_q;
   assign VGA_VISIBLE = vis2_q;
   assign BRAM_ADDR   = addr_q;
   assign LOCKED      = (state_q == StLocked);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (25x20) so whole frames stay short.
module tb_vga_timing_gen;

   localparam int HA = 16, HFP = 2, HSY = 4, HBP = 3;
   localparam int VA = 12, VFP = 2, VSY = 2, VBP = 4;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FRAME = HT * VT;
   localparam int LockLine = 0, Tol = 2, MissMax = 3;

   logic clk, rst_n, sync, sync_en;
   logic hs, vs, vis, locked, hs2, vs2, vis2, locked2;
   logic [13:0] addr, addr2;

   int checks = 0;
   int errors = 0;

   // Reference model: raster position as a single frame index plus genlock bookkeeping
   int m_pos, m_s1, m_s2, m_miss, m_nos;
   bit m_locked, m_seen, m_sync_prev;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .PIX_REP(1), .ADDR_W(14), .LOCK_LINE(LockLine), .LOCK_TOL(Tol), .MISS_MAX(MissMax)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .SYNC(sync), .SYNC_EN(sync_en),
      .VGA_HS(hs), .VGA_VS(vs), .VGA_VISIBLE(vis), .BRAM_ADDR(addr), .LOCKED(locked)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .PIX_REP(2), .ADDR_W(14), .LOCK_LINE(LockLine), .LOCK_TOL(Tol), .MISS_MAX(MissMax)
   ) dut_rep2 (
      .CLK(clk), .RST_N(rst_n), .SYNC(sync), .SYNC_EN(sync_en),
      .VGA_HS(hs2), .VGA_VS(vs2), .VGA_VISIBLE(vis2), .BRAM_ADDR(addr2), .LOCKED(locked2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
         if (errors >= 50) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   endtask

   // Expected outputs for a raster index p; p < 0 means the pipeline still holds reset values
   function automatic bit f_vis(int p);
      if (p < 0) return 1'b0;
      return ((p % HT) < HA) && ((p / HT) < VA);
   endfunction

   function automatic bit f_hs(int p);
      int h;
      if (p < 0) return 1'b1;
      h = p % HT;
      return !(h >= HA + HFP && h < HA + HFP + HSY);
   endfunction

   function automatic bit f_vs(int p);
      int v;
      if (p < 0) return 1'b1;
      v = p / HT;
      return !(v >= VA + VFP && v < VA + VFP + VSY);
   endfunction

   function automatic int f_addr(int p, int rep);
      if (!f_vis(p)) return 0;
      return ((p / HT) % 2) * 8192 + (p % HT) / rep;
   endfunction

   task automatic model_reset();
      m_pos = 0; m_s1 = -1; m_s2 = -1;
      m_locked = 1'b0; m_miss = 0; m_nos = 0; m_seen = 1'b0; m_sync_prev = 1'b0;
   endtask

   task automatic model_step();
      bit sy_edge, wrap_now, load, in_win;
      int v, d;
      sy_edge = sync && !m_sync_prev;
      m_sync_prev = sync;
      m_s2 = m_s1;
      m_s1 = m_pos;
      load = 1'b0;
      wrap_now = (m_pos == FRAME - 1);
      v = m_pos / HT;
      d = ((v - LockLine) % VT + VT) % VT;
      in_win = (d <= Tol) || (d >= VT - Tol);
      if (!m_locked) begin
         if (sy_edge && sync_en) begin
            load = 1'b1; m_locked = 1'b1; m_miss = 0; m_nos = 0; m_seen = 1'b1;
         end
      end else if (!sync_en) begin
         m_locked = 1'b0;
      end else if (sy_edge) begin
         m_nos = 0;
         if (in_win) m_miss = 0;
         else begin
            m_miss++;
            if (m_miss == MissMax) begin load = 1'b1; m_miss = 0; end
         end
         m_seen = !(wrap_now && !load);
      end else if (wrap_now) begin
         if (!m_seen) begin
            m_nos++;
            if (m_nos == 2) m_locked = 1'b0;
         end
         m_seen = 1'b0;
      end
      m_pos = load ? LockLine * HT : (m_pos + 1) % FRAME;
   endtask

   task automatic check_outputs();
      check("hs", hs, f_hs(m_s2));
      check("vs", vs, f_vs(m_s2));
      check("visible", vis, f_vis(m_s2));
      check("addr", addr, f_addr(m_s1, 1));
      check("locked", locked, m_locked);
      check("hs_rep2", hs2, f_hs(m_s2));
      check("vs_rep2", vs2, f_vs(m_s2));
      check("visible_rep2", vis2, f_vis(m_s2));
      check("addr_rep2", addr2, f_addr(m_s1, 2));
      check("locked_rep2", locked2, m_locked);
   endtask

   // One clock: model consumes the inputs seen at the edge, outputs compared mid-cycle
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wait_pos(input int v, input int h);
      int n;
      n = 0;
      while (m_pos != v * HT + h) begin
         tick();
         n++;
         if (n > 2 * FRAME) begin
            check("wait_pos timeout", 32'd1, 32'd0);
            return;
         end
      end
   endtask

   typedef struct {
      int v;
      int h;
      bit en;
      bit exp_locked;
      int exp_v;
      int exp_h;
   } vec_t;

   vec_t tbl[15];
   int n_hs, n_vs, n_vis, r;

   initial begin
      // Edge at (v,h) -> expected LOCKED and counter position on the next clock
      tbl[0]  = '{5, 3, 1'b0, 1'b0, 5, 4};    // free running, genlock disabled
      tbl[1]  = '{7, 5, 1'b1, 1'b1, 0, 0};    // acquire lock
      tbl[2]  = '{0, 0, 1'b1, 1'b1, 0, 1};    // on the lock line
      tbl[3]  = '{1, 4, 1'b1, 1'b1, 1, 5};    // +1 inside window
      tbl[4]  = '{19, 4, 1'b1, 1'b1, 19, 5};  // -1 inside window
      tbl[5]  = '{10, 2, 1'b1, 1'b1, 10, 3};  // miss 1
      tbl[6]  = '{10, 2, 1'b1, 1'b1, 10, 3};  // miss 2
      tbl[7]  = '{10, 2, 1'b1, 1'b1, 0, 0};   // miss 3 -> realign
      tbl[8]  = '{3, 2, 1'b1, 1'b1, 3, 3};    // tol+1 is outside: miss 1
      tbl[9]  = '{2, 6, 1'b1, 1'b1, 2, 7};    // +tol inside, clears misses
      tbl[10] = '{10, 2, 1'b1, 1'b1, 10, 3};  // miss 1 again
      tbl[11] = '{10, 2, 1'b1, 1'b1, 10, 3};  // miss 2, no realign
      tbl[12] = '{5, 1, 1'b0, 1'b0, 5, 2};    // disable drops lock, counters undisturbed
      tbl[13] = '{8, 0, 1'b1, 1'b1, 0, 0};    // relock
      tbl[14] = '{18, 3, 1'b1, 1'b1, 18, 4};  // -tol inside window

      rst_n = 1'b0; sync = 1'b0; sync_en = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // Free run: per-frame totals of sync and visible cycles
      repeat (5) tick();
      n_hs = 0; n_vs = 0; n_vis = 0;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         if (hs == 1'b0) n_hs++;
         if (vs == 1'b0) n_vs++;
         if (vis == 1'b1) n_vis++;
      end
      check("hs low cycles per frame", n_hs, HSY * VT);
      check("vs low cycles per frame", n_vs, VSY * HT);
      check("visible cycles per frame", n_vis, HA * VA);

      for (int i = 0; i < 15; i++) begin
         wait_pos(tbl[i].v, tbl[i].h);
         sync_en = tbl[i].en;
         sync = 1'b1;
         tick();
         sync = 1'b0;
         check($sformatf("vec%0d locked", i), locked, tbl[i].exp_locked);
         tick();
         check($sformatf("vec%0d addr", i), addr, f_addr(tbl[i].exp_v * HT + tbl[i].exp_h, 1));
         tick();
         check($sformatf("vec%0d visible", i), vis, f_vis(tbl[i].exp_v * HT + tbl[i].exp_h));
      end

      // Sync stops: the frame of the last edge is fine, then two edge-less wraps drop lock
      for (int w = 1; w <= 3; w++) begin
         wait_pos(VT - 1, HT - 1);
         tick();
         check($sformatf("nosync wrap%0d locked", w), locked, (w < 3) ? 1 : 0);
      end

      // Edge coincident with the wrap that would otherwise drop lock
      wait_pos(4, 0);
      sync = 1'b1;
      tick();
      sync = 1'b0;
      check("relock locked", locked, 1);
      for (int w = 1; w <= 5; w++) begin
         wait_pos(VT - 1, HT - 1);
         if (w == 3) sync = 1'b1;
         tick();
         sync = 1'b0;
         check($sformatf("coincident wrap%0d locked", w), locked, (w < 5) ? 1 : 0);
      end

      // Reset asserted mid-frame while locked
      wait_pos(6, 0);
      sync = 1'b1;
      tick();
      sync = 1'b0;
      wait_pos(9, 12);
      #2 rst_n = 1'b0;
      #1;
      check("async reset hs", hs, 1);
      check("async reset vs", vs, 1);
      check("async reset visible", vis, 0);
      check("async reset addr", addr, 0);
      check("async reset addr_rep2", addr2, 0);
      check("async reset locked", locked, 0);
      model_reset();
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // Randomised sync/enable activity, with frequent near-lock-line edges
      sync_en = 1'b1;
      for (int i = 0; i < 8000; i++) begin
         r = $urandom_range(0, 999);
         if (r < 12) sync = ~sync;
         else if (r < 14) sync_en = ~sync_en;
         if (m_pos == (VT - 1) * HT + $urandom_range(0, HT - 1) && r > 300) sync = 1'b1;
         if (m_pos == HT + 2) sync = 1'b0;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA output timing generator with genlock, the next generation of the transmit-side timing logic in the HP2VGA FPGA design. It runs in the TX pixel clock domain and generates HS, VS and the visible window. It also drives the line-buffer read address, with pixel replication and ping-pong line banks. It phase-locks its vertical counter to the already-synchronised RX→TX sync pulse using a tolerance window, a miss counter and loss-of-sync detection.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch/sync widths (clocks)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync widths (lines)
- HS_POL / VS_POL, 0 / 0, active sync level (0 = active-low)
- PIX_REP, 1, output clocks per buffer pixel (1 or 2)
- ADDR_W, 14, line-buffer address width; MSB is the bank bit
- LOCK_LINE, 0, v_count value loaded on genlock
- LOCK_TOL, 2, accepted ± line error while locked
- MISS_MAX, 3, consecutive out-of-window syncs before hard realign

Ports:
- CLK  in  1  TX pixel clock (single clock domain)
- RST_N  in  1  asynchronous, active-low reset
- SYNC  in  1  RX→TX frame sync, already 2-flop synchronised to CLK
- SYNC_EN  in  1  genlock enable
- VGA_HS / VGA_VS  out  1  sync outputs, polarity per HS_POL/VS_POL
- VGA_VISIBLE  out  1  high inside the active window
- BRAM_ADDR  out  ADDR_W  line-buffer read address
- LOCKED  out  1  genlock state indicator

## Operation
- Totals:
  - H_TOTAL = sum of the H parameters (default 800).
  - V_TOTAL = sum of the V parameters (default 525).
- Counters:
  - h_count runs 0..H_TOTAL-1.
  - v_count increments when h_count wraps and runs 0..V_TOTAL-1.
  - Both are sized by $clog2 of their total.
- Active and sync regions:
  - Visible when h < H_ACTIVE and v < V_ACTIVE.
  - HS active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; VS uses the same form on v.
- BRAM_ADDR = {v_count[0], h_count/PIX_REP truncated to ADDR_W-1 bits}.
  - The bank bit alternates per line; the RX side writes the opposite bank.
  - Address is 0 outside the visible region.
- SYNC rising edge is detected with one internal register (sync_edge).
- State machine:
  - FREE:
    - On sync_edge with SYNC_EN=1: h←0, v←LOCK_LINE, miss←0, nosync←0, go to LOCKED.
  - LOCKED:
    - On sync_edge with v within [LOCK_LINE−LOCK_TOL, LOCK_LINE+LOCK_TOL], evaluated modulo V_TOTAL: miss←0, no counter change.
    - On sync_edge out of window: miss←miss+1. On the MISS_MAX-th consecutive miss: h←0, v←LOCK_LINE, miss←0, remain LOCKED.
    - Each v wrap with no sync_edge since the previous wrap: nosync←nosync+1. At 2: go to FREE. Counters keep running.
    - SYNC_EN=0: go to FREE immediately, no counter disturbance.
- LOCKED output = (state == LOCKED).

## Timing
- Reset values (async):
  - h=0, v=0, state FREE, miss=0, nosync=0.
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_VISIBLE=0, BRAM_ADDR=0, LOCKED=0.
- Latency:
  - BRAM_ADDR is registered, 1 clock after the counter state.
  - HS, VS and VISIBLE are delayed 2 clocks, so RAM data (1-clock read latency) aligns with VISIBLE.
- Genlock load: counters show h=0, v=LOCK_LINE on the clock after sync_edge is detected. Outputs follow with the latencies above.
- Simultaneous sync_edge and v wrap in one cycle: the edge has priority; nosync←0.
- SYNC held high gives a single edge only.
- Reset mid-frame returns all state to reset values asynchronously. The first frame starts at h=0, v=0.

## Structure
- Shared package vga_timing_pkg holds:
  - state enum {FREE, LOCKED};
  - default 640×480 timing constants;
  - a function returning the in-window test modulo V_TOTAL.
- One sub-module, sync_region, is instantiated twice (horizontal and vertical). It is a parametrised comparator that produces active and sync flags from a count.

## Test plan
- Reset release, SYNC_EN=0: HS low for 96 clocks every 800; VS low for 2 lines every 525; VISIBLE high for 640×480; LOCKED stays 0.
- PIX_REP=2: BRAM_ADDR low bits step 0,0,1,1…319,319 across the line; bank bit toggles each line.
- SYNC_EN=1, SYNC edge at v=200: the next clock shows v=0, h=0; LOCKED=1; the following edges arriving at v=0 keep the counters undisturbed.
- While locked, edges at v=1 and v=524 (inside ±2) cause no realign. Three consecutive edges at v=10 cause a realign on the third.
- Locked, SYNC stops: LOCKED drops at the second v wrap without an edge. Edge coincident with a wrap keeps LOCKED=1.
- Assert RST_N low at h=400, v=300: all outputs take reset values immediately; the state returns to FREE.
